data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the core's memory-stage load/store port: it accepts one word or byte access per request and services it with a fixed, parameterised number of wait states. It produces the load data the writeback stage consumes, plus a stall that the hazard unit uses to freeze the pipeline while an access is outstanding. It owns the data storage array and checks addresses for range and alignment.

## Interface
Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; power of two.
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0; word-aligned.
- WAIT_CYCLES, 2, wait states between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present; held stable until the rsp_valid cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  1  0 = word, 1 = byte.
- req_addr  in  32  byte address (ALU result of the memory stage).
- req_wdata  in  32  store data; a byte store uses bits [7:0].
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  32  load data, valid when rsp_valid=1; otherwise 0.
- rsp_err  out  1  valid with rsp_valid: out-of-range or misaligned access.
- stall  out  1  combinational: req_valid & ~rsp_valid.

## Operation
- FSM states:
  - IDLE: on req_valid, latch we, size, addr and wdata; load wait_cnt=WAIT_CYCLES. Go to RESP if WAIT_CYCLES=0, else to WAIT.
  - WAIT: decrement wait_cnt; go to RESP when wait_cnt reaches 1.
  - RESP: assert rsp_valid. A load drives rsp_rdata and a store performs the array write in this cycle. Always return to IDLE.
- Address check:
  - offset = addr − BASE_ADDR, modulo-2^32 subtraction.
  - Error if offset ≥ 4·DEPTH_WORDS (wrap-around from addr < BASE_ADDR counts as out of range).
  - Error if size=word and addr[1:0]≠0.
- Error access: rsp_err=1, rsp_rdata=0, no array write. A response is still produced, so the requester never deadlocks.
- Word load: rsp_rdata = mem[offset>>2].
- Byte load: rsp_rdata = {24'b0, byte lane addr[1:0]}, where lane 0 = bits [7:0] (little-endian), zero-extended.
- Byte store: only the addressed lane of mem[offset>>2] is updated.
- Requests are not pipelined: a new request is accepted only in IDLE. The cycle after RESP is IDLE, so back-to-back requests cost WAIT_CYCLES+2 cycles each.
- Request fields are sampled only at acceptance; changes while in WAIT are ignored.
- The array is not reset; its contents are undefined until written.

## Timing
- Reset, asynchronous and active-low: state=IDLE, wait_cnt=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. While req_valid=0, stall=0.
- Reset asserted mid-access: the access is abandoned and a pending store is not written. After release, a still-asserted req_valid is accepted as a new request.
- Acceptance at cycle T gives rsp_valid at T+WAIT_CYCLES+1. stall is high for cycles T..T+WAIT_CYCLES and low in the RESP cycle, so the memory stage advances on that edge.
- A store is visible to a load accepted in any later IDLE cycle (read-after-write via the array; no bypass needed).
- rsp_rdata and rsp_err are registered outputs, and they are 0 outside RESP.

## Structure
- The shared package holds:
  - the state enum: IDLE, WAIT, RESP;
  - size encoding constants: SIZE_WORD, SIZE_BYTE;
  - a function computing the byte-lane write mask from size and addr[1:0].
- One sub-module, dmem_array:
  - synchronous single-port storage of DEPTH_WORDS×32;
  - per-byte write enables;
  - combinational read of the indexed word.
- Range/alignment check, FSM, wait counter and lane extraction live in data_mem_responder.

## Test plan
- WAIT_CYCLES=2: word store 32'hDEAD_BEEF to 0x10 at cycle T, then a word load from 0x10.
  - Store: rsp_valid at T+3, with stall high T..T+2.
  - Load: rsp_rdata=32'hDEAD_BEEF, rsp_err=0.
- Byte store 8'hA5 to 0x13 over word 0x11223344 at 0x10:
  - word load returns 0xA5223344;
  - byte load from 0x13 returns 32'h0000_00A5.
- Misaligned word load from 0x12 → rsp_err=1, rsp_rdata=0.
- Out-of-range word store to 4·DEPTH_WORDS → rsp_err=1, no write. A load of word 0 is unchanged.
- Reset pulled low during WAIT of a store to 0x20:
  - all outputs go to 0 immediately;
  - a later load of 0x20 returns the old value.
- WAIT_CYCLES=0, back-to-back loads held with req_valid=1 → rsp_valid every second cycle, never two consecutive cycles.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared types and helpers for the data memory responder: FSM states, access
// size encoding and the byte-lane write mask.
package data_mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  // Lane 0 is bits [7:0] (little-endian); a word access enables every lane.
  function automatic logic [3:0] lane_mask(input logic size, input logic [1:0] lane);
    if (size == SIZE_BYTE) begin
      return 4'b0001 << lane;
    end
    return 4'b1111;
  endfunction

endpackage

// File: rtl/data_mem_responder_array.sv
// Single-port DEPTH_WORDS x 32 storage with per-byte write enables and an
// asynchronous read of the indexed word. Contents are never reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) begin
        r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage load/store responder: range/alignment check, fixed wait-state
// FSM, byte-lane extraction and the stall seen by the hazard unit.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic        req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        stall
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

  state_t      r_state;
  logic [3:0]  r_wait_cnt;
  logic        r_we;
  logic        r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic        w_accept;
  logic        w_enter_resp;
  logic [31:0] w_addr;
  logic        w_size;
  logic        w_we;
  logic [31:0] w_offset;
  logic        w_err;
  logic [AW-1:0] w_idx;
  logic [3:0]  w_be;
  logic [31:0] w_arr_wdata;
  logic [31:0] w_arr_rdata;
  logic [31:0] w_load_data;

  assign w_accept = (r_state == IDLE) && req_valid;

  // In IDLE the live request is decoded so a zero-wait access can load its
  // response on the acceptance edge; afterwards only the latched copy counts.
  assign w_addr = (r_state == IDLE) ? req_addr : r_addr;
  assign w_size = (r_state == IDLE) ? req_size : r_size;
  assign w_we   = (r_state == IDLE) ? req_we   : r_we;

  // Modulo-2^32 subtraction: addresses below BASE_ADDR wrap to huge offsets.
  assign w_offset = w_addr - BASE_ADDR;
  assign w_err    = (w_offset >= SPAN) ||
                    ((w_size == SIZE_WORD) && (w_addr[1:0] != 2'b00));
  assign w_idx    = w_offset[AW+1:2];

  assign w_enter_resp = ((r_state == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                        ((r_state == WAIT) && (r_wait_cnt == 4'd1));

  assign w_be        = ((r_state == RESP) && r_we && !w_err) ? lane_mask(r_size, r_addr[1:0]) : 4'b0000;
  assign w_arr_wdata = (r_size == SIZE_BYTE) ? {4{r_wdata[7:0]}} : r_wdata;

  always_comb begin
    w_load_data = 32'h0;
    if (!w_err && !w_we) begin
      if (w_size == SIZE_BYTE) begin
        w_load_data = {24'h0, lane_byte(w_arr_rdata, w_addr[1:0])};
      end else begin
        w_load_data = w_arr_rdata;
      end
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .i_be   (w_be),
    .i_idx  (w_idx),
    .i_wdata(w_arr_wdata),
    .o_rdata(w_arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= req_we;
      r_size  <= req_size;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_wait_cnt  <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
      if (w_enter_resp) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= w_load_data;
        r_rsp_err   <= w_err;
      end
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_wait_cnt <= 4'(WAIT_CYCLES);
            r_state    <= (WAIT_CYCLES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_wait_cnt <= r_wait_cnt - 4'd1;
          if (r_wait_cnt == 4'd1) begin
            r_state <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign stall     = req_valid && !r_rsp_valid;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder with a word-array reference model;
// a second zero-wait instance with a non-zero base covers back-to-back timing.
module tb_data_mem_responder;

  localparam int          WA     = 2;
  localparam int          A_WORDS = 256;
  localparam logic [31:0] B_BASE = 32'h0000_1000;
  localparam int          B_WORDS = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_req_valid = 1'b0, a_we = 1'b0, a_size = 1'b0;
  logic [31:0] a_addr = 32'h0, a_wdata = 32'h0;
  logic        a_rsp_valid, a_err, a_stall;
  logic [31:0] a_rdata;

  logic        b_req_valid = 1'b0, b_we = 1'b0, b_size = 1'b0;
  logic [31:0] b_addr = 32'h0, b_wdata = 32'h0;
  logic        b_rsp_valid, b_err, b_stall;
  logic [31:0] b_rdata;

  data_mem_responder #(.DEPTH_WORDS(A_WORDS), .BASE_ADDR(32'h0), .WAIT_CYCLES(WA)) dut (
    .clk(clk), .reset(rst_n), .req_valid(a_req_valid), .req_we(a_we), .req_size(a_size),
    .req_addr(a_addr), .req_wdata(a_wdata), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata),
    .rsp_err(a_err), .stall(a_stall));

  data_mem_responder #(.DEPTH_WORDS(B_WORDS), .BASE_ADDR(B_BASE), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(rst_n), .req_valid(b_req_valid), .req_we(b_we), .req_size(b_size),
    .req_addr(b_addr), .req_wdata(b_wdata), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata),
    .rsp_err(b_err), .stall(b_stall));

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] mdl [A_WORDS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Caller is #1 after a rising edge with the responder idle.
  task automatic acc_a(input logic we, input logic size, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd, output logic err);
    int lat = 0;
    a_req_valid = 1'b1; a_we = we; a_size = size; a_addr = addr; a_wdata = wdata;
    #1 check("stall_accept", 32'(a_stall), 32'd1);
    do begin
      @(posedge clk); #1;
      lat++;
      if (!a_rsp_valid) check("stall_wait", 32'(a_stall), 32'd1);
    end while (!a_rsp_valid && lat < 40);
    check("latency", lat, WA + 1);
    check("stall_resp", 32'(a_stall), 32'd0);
    rd = a_rdata; err = a_err;
    a_req_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_valid", 32'(a_rsp_valid), 32'd0);
    check("idle_rdata", a_rdata, 32'd0);
  endtask

  task automatic run_a(input logic we, input logic size, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd);
    logic [31:0] off, e_rd;
    logic e_err, err;
    int idx, lane;
    off   = addr;
    e_err = (off >= 32'(4 * A_WORDS)) || (size == 1'b0 && addr[1:0] != 2'b00);
    idx   = int'(off >> 2) % A_WORDS;
    lane  = int'(addr[1:0]);
    e_rd  = 32'h0;
    if (!e_err && !we) e_rd = size ? {24'h0, mdl[idx][8*lane +: 8]} : mdl[idx];
    acc_a(we, size, addr, wdata, rd, err);
    check("err", 32'(err), 32'(e_err));
    if (e_err || !we) check(we ? "err_store_rdata" : "load_rdata", rd, e_rd);
    if (we && !e_err) begin
      if (size) mdl[idx][8*lane +: 8] = wdata[7:0];
      else      mdl[idx] = wdata;
    end
  endtask

  task automatic acc_b(input logic we, input logic size, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rd, output logic err);
    int lat = 0;
    b_req_valid = 1'b1; b_we = we; b_size = size; b_addr = addr; b_wdata = wdata;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!b_rsp_valid && lat < 40);
    check("b_latency", lat, 1);
    rd = b_rdata; err = b_err;
    b_req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd, old20;
    logic err;
    int pulses;
    logic prev;

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(a_rsp_valid), 32'd0);
    check("rst_rdata", a_rdata, 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_stall", 32'(a_stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < A_WORDS; i++) run_a(1'b1, 1'b0, 32'(i * 4), $urandom, rd);

    run_a(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, rd);
    run_a(1'b0, 1'b0, 32'h10, 32'h0, rd);
    check("raw_deadbeef", rd, 32'hDEAD_BEEF);

    run_a(1'b1, 1'b0, 32'h10, 32'h1122_3344, rd);
    run_a(1'b1, 1'b1, 32'h13, 32'hFFFF_FFA5, rd);
    run_a(1'b0, 1'b0, 32'h10, 32'h0, rd);
    check("byte_merge", rd, 32'hA522_3344);
    run_a(1'b0, 1'b1, 32'h13, 32'h0, rd);
    check("byte_load", rd, 32'h0000_00A5);

    acc_a(1'b0, 1'b0, 32'h12, 32'h0, rd, err);
    check("misalign_err", 32'(err), 32'd1);
    check("misalign_rdata", rd, 32'd0);

    acc_a(1'b1, 1'b0, 32'(4 * A_WORDS), 32'hBAD0_BAD0, rd, err);
    check("oor_err", 32'(err), 32'd1);
    run_a(1'b0, 1'b0, 32'h0, 32'h0, rd);

    old20 = mdl[8];
    a_req_valid = 1'b1; a_we = 1'b1; a_size = 1'b0; a_addr = 32'h20; a_wdata = ~old20;
    @(posedge clk); #1;
    check("pre_rst_stall", 32'(a_stall), 32'd1);
    rst_n = 1'b0;
    a_req_valid = 1'b0;
    #1;
    check("midrst_valid", 32'(a_rsp_valid), 32'd0);
    check("midrst_rdata", a_rdata, 32'd0);
    check("midrst_err", 32'(a_err), 32'd0);
    check("midrst_stall", 32'(a_stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_a(1'b0, 1'b0, 32'h20, 32'h0, rd);
    check("abandoned_store", rd, old20);

    for (int i = 0; i < 400; i++) begin
      logic we, size;
      logic [31:0] addr;
      we   = 1'($urandom);
      size = 1'($urandom);
      addr = 32'($urandom_range(0, 4 * A_WORDS + 60));
      if (($urandom % 8) != 0 && !size) addr[1:0] = 2'b00;
      run_a(we, size, addr, $urandom, rd);
    end

    b_req_valid = 1'b1; b_we = 1'b0; b_size = 1'b0; b_addr = B_BASE + 32'h8;
    pulses = 0; prev = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("b2b_consecutive", 32'(prev & b_rsp_valid), 32'd0);
      if (b_rsp_valid) begin
        check("b2b_err", 32'(b_err), 32'd0);
        pulses++;
      end
      prev = b_rsp_valid;
    end
    b_req_valid = 1'b0;
    check("b2b_pulses", pulses, 6);
    @(posedge clk); #1;

    acc_b(1'b0, 1'b0, B_BASE - 32'd4, 32'h0, rd, err);
    check("b_below_base", 32'(err), 32'd1);
    acc_b(1'b1, 1'b0, B_BASE + 32'(4 * B_WORDS), 32'h0, rd, err);
    check("b_above_top", 32'(err), 32'd1);
    acc_b(1'b1, 1'b0, B_BASE + 32'(4 * B_WORDS - 4), 32'hCAFE_F00D, rd, err);
    check("b_top_store_err", 32'(err), 32'd0);
    acc_b(1'b1, 1'b1, B_BASE + 32'(4 * B_WORDS - 3), 32'h0000_0077, rd, err);
    check("b_byte_store_err", 32'(err), 32'd0);
    acc_b(1'b0, 1'b0, B_BASE + 32'(4 * B_WORDS - 4), 32'h0, rd, err);
    check("b_top_load", rd, 32'hCAFE_770D);
    acc_b(1'b0, 1'b1, B_BASE + 32'(4 * B_WORDS - 1), 32'h0, rd, err);
    check("b_byte_load", rd, 32'h0000_00CA);
    acc_b(1'b0, 1'b0, B_BASE + 32'h2, 32'h0, rd, err);
    check("b_misalign", 32'(err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
